// File: rtl/ysyx_23060191_ifq_pkg.sv
// Shared constants for the instruction fetch queue: datapath width and
// the occupancy value the queue returns to on reset or flush.
package ysyx_23060191_ifq_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int COUNT_RST = 0;

endpackage

// File: rtl/ysyx_23060191_fifo_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port; contents are intentionally left unreset.
module ysyx_23060191_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_23060191_ifq.sv
// Instruction fetch queue between IFU and IDU: a small {pc, inst} FIFO with
// valid/ready on both sides and a flush that drops every in-flight entry.
module ysyx_23060191_ifq
  import ysyx_23060191_ifq_pkg::*;
#(
  parameter int CPU_WIDTH = ysyx_23060191_ifq_pkg::CPU_WIDTH,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CPU_WIDTH-1:0]       in_pc,
  input  logic [CPU_WIDTH-1:0]       in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CPU_WIDTH-1:0]       out_pc,
  output logic [CPU_WIDTH-1:0]       out_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full, empty, push, pop;
  logic [2*CPU_WIDTH-1:0] rdata;

  // The MSB of each pointer is a wrap bit, so equal indices mean empty when
  // the laps agree and full when they differ.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = PW'(COUNT_RST);
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= PW'(COUNT_RST);
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  ysyx_23060191_fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(2 * CPU_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push & ~rstn),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i ({in_pc, in_inst}),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  assign out_pc   = rdata[2*CPU_WIDTH-1:CPU_WIDTH];
  assign out_inst = rdata[CPU_WIDTH-1:0];

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rstn) begin
      assert (!(push && full));
      assert (!(pop && empty));
      assert (count_q <= PW'(DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060191_ifq.sv
// Self-checking bench for the fetch queue: directed phases plus a random
// phase, all compared each cycle against a queue-based reference model.
module tb_ysyx_23060191_ifq;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] inPc = '0;
  logic [31:0] inInst = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] outPc;
  logic [31:0] outInst;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [31:0] modelPc[$];
  logic [31:0] modelInst[$];
  logic [31:0] pendPc = 32'h8000_0000;
  logic [31:0] pendInst = 32'h0;

  ysyx_23060191_ifq #(.CPU_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_pc     (inPc),
    .in_inst   (inInst),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_pc    (outPc),
    .out_inst  (outInst),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Compares every observable output with what the model queue implies.
  task automatic checkOutput();
    logic       expValid;
    logic       expReady;
    logic [2:0] expCount;
    expValid = (modelPc.size() != 0);
    expReady = (modelPc.size() < DEPTH);
    expCount = 3'(modelPc.size());
    checks++;
    assert (outValid === expValid) else begin
      errors++;
      $error("[TB] FAIL out_valid obs=%0b exp=%0b", outValid, expValid);
    end
    checks++;
    assert (inReady === expReady) else begin
      errors++;
      $error("[TB] FAIL in_ready obs=%0b exp=%0b", inReady, expReady);
    end
    checks++;
    assert (count === expCount) else begin
      errors++;
      $error("[TB] FAIL count obs=%0d exp=%0d", count, expCount);
    end
    if (expValid) begin
      checks++;
      assert (outPc === modelPc[0]) else begin
        errors++;
        $error("[TB] FAIL out_pc obs=%h exp=%h", outPc, modelPc[0]);
      end
      checks++;
      assert (outInst === modelInst[0]) else begin
        errors++;
        $error("[TB] FAIL out_inst obs=%h exp=%h", outInst, modelInst[0]);
      end
    end
  endtask

  // Drives one cycle; the pending instruction is held until the model says
  // it was accepted, which keeps the IFU hold-stable rule.
  task automatic applyStimulus(input bit v, input bit ordy, input bit fl,
                               input bit rs, input bit doCheck);
    bit accepted;
    bit popped;
    inValid  = v;
    outReady = ordy;
    flush    = fl;
    rstn     = rs;
    inPc     = pendPc;
    inInst   = pendInst;
    #1;
    if (doCheck) checkOutput();
    if (rs || fl) begin
      modelPc.delete();
      modelInst.delete();
    end else begin
      accepted = v && (modelPc.size() < DEPTH);
      popped   = ordy && (modelPc.size() > 0);
      if (popped) begin
        void'(modelPc.pop_front());
        void'(modelInst.pop_front());
      end
      if (accepted) begin
        modelPc.push_back(pendPc);
        modelInst.push_back(pendInst);
        pendPc   = pendPc + 32'd4;
        pendInst = $urandom;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic setPending(input logic [31:0] pc, input logic [31:0] inst);
    pendPc   = pc;
    pendInst = inst;
  endtask

  initial begin
    @(posedge clk);
    #1;

    $display("[TB] reset with in_valid high");
    setPending(32'h8000_0000, $urandom);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] streaming");
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 1);

    $display("[TB] fill and back-pressure");
    setPending(32'h8000_0010, $urandom);
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 1);

    $display("[TB] full simultaneous push/pop");
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0, 1);

    $display("[TB] flush with three queued");
    applyStimulus(0, 1, 0, 0, 1);
    setPending(pendPc, 32'h0000_0013);
    applyStimulus(1, 0, 1, 0, 1);
    setPending(32'h8000_0100, $urandom);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);

    $display("[TB] reset while full and stalled");
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0,
                    ($urandom % 20) == 0, ($urandom % 50) == 0, 1);
    end
    applyStimulus(0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
